// File: rtl/dmem_pkg.sv
// Shared types and constants for the risc_16 data-memory responder.
// Optional parity support is enabled with MEM_PARITY_EN.
package dmem_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic              err;
        logic [WORD_W-1:0] rdata;
    } rsp_t;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_parity(input logic [WORD_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD_W storage, synchronous write, asynchronous read.
// With MEM_PARITY_EN a resettable parity column sits beside the data.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic              clk,
`ifdef MEM_PARITY_EN
    input  logic              rst_n,
    input  logic              wpar,
    output logic              rpar,
`endif
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Data words are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

`ifdef MEM_PARITY_EN
    logic [DEPTH-1:0] par;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par <= '0;
        end else if (we) begin
            par[addr] <= wpar;
        end
    end

    assign rpar = par[addr];
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the risc_16 data-memory interface with configurable wait states.
// Define MEM_PARITY_EN to add per-word parity and the parity_inject input.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
`ifdef MEM_PARITY_EN
    input  logic              parity_inject,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WIDX_W = ADDR_W - 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    ready_q;
    logic                    valid_q;
    rsp_t                    rsp_q;

    logic                    cap_we;
    logic [ADDR_W-1:0]       cap_addr;
    logic [WORD_W-1:0]       cap_wdata;
`ifdef MEM_PARITY_EN
    logic                    cap_inject;
`endif

    logic [WIDX_W-1:0]       word_idx;
    logic                    fault;
    logic                    mem_we;
    logic [WORD_W-1:0]       mem_rdata;
    logic                    access_err;
    logic [WORD_W-1:0]       access_rdata;

    // Address decode on the captured request.
    assign word_idx = cap_addr[ADDR_W-1:1];
    assign fault    = cap_addr[0] | (32'(word_idx) >= DEPTH);

    // Reset wins over a store whose ACCESS edge coincides with it.
    assign mem_we = (state == ACCESS) && cap_we && !fault && rst_n;

`ifdef MEM_PARITY_EN
    logic mem_rpar;
    logic par_bad;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .wpar  (even_parity(cap_wdata) ^ cap_inject),
        .rpar  (mem_rpar),
        .we    (mem_we),
        .addr  (IDX_W'(word_idx)),
        .wdata (cap_wdata),
        .rdata (mem_rdata)
    );

    assign par_bad    = !cap_we && (even_parity(mem_rdata) != mem_rpar);
    assign access_err = fault | par_bad;
`else
    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (IDX_W'(word_idx)),
        .wdata (cap_wdata),
        .rdata (mem_rdata)
    );

    assign access_err = fault;
`endif

    assign access_rdata = (cap_we || access_err) ? '0 : mem_rdata;

    // Request/response FSM; rsp_valid rises one cycle into RESP so the
    // response registers are settled before the core can see it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            rsp_q     <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
`ifdef MEM_PARITY_EN
            cap_inject <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
`ifdef MEM_PARITY_EN
                        cap_inject <= parity_inject;
`endif
                        ready_q  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                ACCESS: begin
                    rsp_q.err   <= access_err;
                    rsp_q.rdata <= access_rdata;
                    state       <= RESP;
                end
                RESP: begin
                    if (valid_q && rsp_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
// Parity cases are exercised when MEM_PARITY_EN is defined.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [15:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [15:0] b_req_addr, b_req_wdata, b_rsp_rdata;
`ifdef MEM_PARITY_EN
    logic        a_inj, b_inj;
`endif

    data_mem_responder #(.DEPTH(256), .ADDR_W(16), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
`ifdef MEM_PARITY_EN
        .parity_inject(a_inj),
`endif
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    data_mem_responder #(.DEPTH(256), .ADDR_W(16), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
`ifdef MEM_PARITY_EN
        .parity_inject(b_inj),
`endif
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        inj;
        logic [15:0] rdata;
        logic        err;
    } vec_t;

    exp_t a_q[$];
    exp_t b_q[$];
    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic inj, input logic [15:0] rdata, input logic err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.inj = inj; v.rdata = rdata; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic drive_a(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic inj);
        @(negedge clk);
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = wdata;
`ifdef MEM_PARITY_EN
        a_inj       = inj;
`else
        if (inj) a_req_wdata = wdata;
`endif
    endtask

    // Returns on the accepting posedge, or after a bounded number of cycles.
    task automatic wait_accept_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (a_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Counts edges from the accept edge until rsp_valid is seen; 99 on timeout.
    task automatic wait_valid_a(output int lat);
        lat = 0;
        while (lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (a_rsp_valid) break;
        end
        if (!a_rsp_valid) lat = 99;
    endtask

    task automatic txn_a(input string name, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic inj,
                         input logic [15:0] rdata, input logic err);
        bit   ok;
        int   lat;
        exp_t e;
        drive_a(we, addr, wdata, inj);
        wait_accept_a(ok);
        check({name, " accepted"}, 32'(ok), 32'd1);
        if (!ok) begin
            a_req_valid = 1'b0;
            return;
        end
        e.rdata = rdata;
        e.err   = err;
        a_q.push_back(e);
        #1 a_req_valid = 1'b0;
        wait_valid_a(lat);
        check({name, " latency"}, 32'(lat), 32'd4);
        if (!a_rsp_valid) begin
            a_q.delete();
            return;
        end
        e = a_q.pop_front();
        check({name, " rdata"}, 32'(a_rsp_rdata), 32'(e.rdata));
        check({name, " err"}, 32'(a_rsp_err), 32'(e.err));
        a_rsp_ready = 1'b1;
        @(posedge clk);
        #1 a_rsp_ready = 1'b0;
        check({name, " valid drops"}, 32'(a_rsp_valid), 32'd0);
        check({name, " ready back"}, 32'(a_req_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   lat;
        exp_t e;
        int   acc_cnt, rsp_cnt, outst, overlap, acc_cyc;
        bit   seen;

        a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 0;
`ifdef MEM_PARITY_EN
        a_inj = 0; b_inj = 0;
`endif

        add_vec(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b0);
        add_vec(1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 1'b0);
        add_vec(1'b0, 16'h0011, 16'h0000, 1'b0, 16'h0000, 1'b1);
        add_vec(1'b0, 16'h0200, 16'h0000, 1'b0, 16'h0000, 1'b1);
        add_vec(1'b0, 16'h0201, 16'h0000, 1'b0, 16'h0000, 1'b1);
        add_vec(1'b1, 16'h0011, 16'h5555, 1'b0, 16'h0000, 1'b1);
        add_vec(1'b1, 16'h0200, 16'h7777, 1'b0, 16'h0000, 1'b1);
        add_vec(1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 1'b0);
        add_vec(1'b1, 16'h01FE, 16'hA5A5, 1'b0, 16'h0000, 1'b0);
        add_vec(1'b0, 16'h01FE, 16'h0000, 1'b0, 16'hA5A5, 1'b0);
        add_vec(1'b1, 16'h0000, 16'h8001, 1'b0, 16'h0000, 1'b0);
        add_vec(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h8001, 1'b0);
`ifdef MEM_PARITY_EN
        add_vec(1'b1, 16'h0040, 16'h00FF, 1'b1, 16'h0000, 1'b0);
        add_vec(1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b1);
        add_vec(1'b1, 16'h0040, 16'h00FF, 1'b0, 16'h0000, 1'b0);
        add_vec(1'b0, 16'h0040, 16'h0000, 1'b0, 16'h00FF, 1'b0);
`endif

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        check("reset a req_ready", 32'(a_req_ready), 32'd0);
        check("reset a rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("reset a rsp_rdata", 32'(a_rsp_rdata), 32'd0);
        check("reset a rsp_err", 32'(a_rsp_err), 32'd0);
        check("reset b req_ready", 32'(b_req_ready), 32'd0);
        check("reset b rsp_valid", 32'(b_rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            txn_a($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  vecs[i].inj, vecs[i].rdata, vecs[i].err);
        end

        // Response back-pressure: outputs hold while rsp_ready stays low.
        drive_a(1'b0, 16'h0010, 16'h0000, 1'b0);
        wait_accept_a(ok);
        check("hold accepted", 32'(ok), 32'd1);
        e.rdata = 16'hBEEF;
        e.err   = 1'b0;
        a_q.push_back(e);
        wait_valid_a(lat);
        check("hold latency", 32'(lat), 32'd4);
        e = a_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d rsp_valid", i), 32'(a_rsp_valid), 32'd1);
            check($sformatf("hold%0d rsp_rdata", i), 32'(a_rsp_rdata), 32'(e.rdata));
            check($sformatf("hold%0d rsp_err", i), 32'(a_rsp_err), 32'(e.err));
            check($sformatf("hold%0d req_ready", i), 32'(a_req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        @(posedge clk);
        #1 a_rsp_ready = 1'b0;
        check("hold released rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("hold released req_ready", 32'(a_req_ready), 32'd1);

        // Reset during WAIT discards the captured store.
        txn_a("pre 0x20", 1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0000, 1'b0);
        drive_a(1'b1, 16'h0020, 16'h1234, 1'b0);
        wait_accept_a(ok);
        check("rst-wait accepted", 32'(ok), 32'd1);
        #1 a_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst-wait req_ready", 32'(a_req_ready), 32'd0);
        check("rst-wait rsp_valid", 32'(a_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("rst-wait req_ready 2", 32'(a_req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_q.delete();
        txn_a("post-rst 0x20", 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h1111, 1'b0);

        // Reset on the ACCESS edge also blocks the write.
        txn_a("pre 0x22", 1'b1, 16'h0022, 16'h2222, 1'b0, 16'h0000, 1'b0);
        drive_a(1'b1, 16'h0022, 16'h9999, 1'b0);
        wait_accept_a(ok);
        check("rst-access accepted", 32'(ok), 32'd1);
        #1 a_req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst-access rsp_valid", 32'(a_rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_q.delete();
        txn_a("post-rst 0x22", 1'b0, 16'h0022, 16'h0000, 1'b0, 16'h2222, 1'b0);

        // WAIT_CYCLES=0 instance with req_valid held high continuously.
        acc_cnt = 0; rsp_cnt = 0; outst = 0; overlap = 0; acc_cyc = 0; seen = 1'b1;
        @(negedge clk);
        b_rsp_ready = 1'b1;
        b_req_we    = 1'b1;
        b_req_addr  = 16'h0030;
        b_req_wdata = 16'h4321;
        b_req_valid = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk);
            if (b_rsp_valid && !seen) begin
                seen = 1'b1;
                check($sformatf("b latency txn%0d", acc_cnt), 32'(cyc - acc_cyc - 1), 32'd2);
            end
            if (b_rsp_valid && b_rsp_ready) begin
                if (b_q.size() > 0) begin
                    e = b_q.pop_front();
                    check($sformatf("b rdata rsp%0d", rsp_cnt), 32'(b_rsp_rdata), 32'(e.rdata));
                    check($sformatf("b err rsp%0d", rsp_cnt), 32'(b_rsp_err), 32'(e.err));
                end else begin
                    check("b unexpected response", 32'd1, 32'(b_q.size()));
                end
                rsp_cnt++;
                outst--;
            end
            if (b_req_valid && b_req_ready) begin
                e.rdata = b_req_we ? 16'h0000 : 16'h4321;
                e.err   = 1'b0;
                b_q.push_back(e);
                acc_cnt++;
                outst++;
                if (outst > 1) overlap++;
                acc_cyc = cyc;
                seen = 1'b0;
                #1 b_req_we = 1'b0;
            end
        end
        #1 b_req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            if (b_rsp_valid && b_rsp_ready && b_q.size() > 0) begin
                e = b_q.pop_front();
                check("b drain rdata", 32'(b_rsp_rdata), 32'(e.rdata));
                rsp_cnt++;
            end
        end
        check("b overlap count", 32'(overlap), 32'd0);
        check("b accepts == responses", 32'(acc_cnt), 32'(rsp_cnt));
        check("b accepts >= 12", 32'(acc_cnt >= 12), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
